microseq_ctrl: RTL

//  Microsequencer for the microprogrammed ARM control unit; owns the control-store address register (uaddr).

---
 rtl/microseq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/microseq_ctrl.sv
// Microsequencer for the microprogrammed control unit: next-address selection and memory-handshake stall.
// Optional MOC watchdog enabled by defining MICROSEQ_TIMEOUT_EN.
module microseq_ctrl #(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(8'h00),
  parameter logic [ADDR_W-1:0] FETCH_ADDR = ADDR_W'(8'h01)
`ifdef MICROSEQ_TIMEOUT_EN
  ,
  parameter logic [ADDR_W-1:0] TRAP_ADDR   = ADDR_W'(8'hFE),
  parameter int unsigned       MOC_TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] enc_addr,
  input  logic [ADDR_W-1:0] cr_target,
  input  logic [2:0]        cr_ns,
  input  logic [1:0]        cr_csel,
  input  logic              cr_inv,
  input  logic [3:0]        cond_in,
  input  logic              cr_mfa,
  input  logic              moc,
  output logic [ADDR_W-1:0] uaddr,
  output logic [1:0]        ns_sel,
  output logic              stall,
  output logic [1:0]        seq_state,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] uaddr_nx;
  logic [ADDR_W-1:0] next_addr;
  logic              cond_s;
  logic              advance;

`ifdef MICROSEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MOC_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             terr_nx;
`endif

  assign cond_s  = cond_in[cr_csel] ^ cr_inv;
  assign advance = ~(cr_mfa & ~moc);
  assign stall   = ~advance;

  // Next-state code to {M1,M0}; conditional codes pick between two sources.
  always_comb begin
    ns_sel = 2'b00;
    case (cr_ns)
      3'b000:  ns_sel = 2'b00;
      3'b001:  ns_sel = 2'b01;
      3'b010:  ns_sel = 2'b10;
      3'b011:  ns_sel = 2'b11;
      3'b100:  ns_sel = cond_s ? 2'b10 : 2'b00;
      3'b101:  ns_sel = cond_s ? 2'b10 : 2'b11;
      3'b110:  ns_sel = cond_s ? 2'b00 : 2'b11;
      default: ns_sel = cond_s ? 2'b10 : 2'b01;
    endcase
  end

  always_comb begin
    next_addr = uaddr;
    case (ns_sel)
      2'b00:   next_addr = enc_addr;
      2'b01:   next_addr = FETCH_ADDR;
      2'b10:   next_addr = cr_target;
      default: next_addr = uaddr + ADDR_W'(1);
    endcase
  end

  // Sequencer next-state: RUN advances or drops into WAIT until moc arrives.
  always_comb begin
    state_nx = state;
    uaddr_nx = uaddr;
`ifdef MICROSEQ_TIMEOUT_EN
    cnt_nx  = cnt;
    terr_nx = timeout_err;
`endif
    case (state)
      RUN: begin
        if (advance) begin
          uaddr_nx = next_addr;
        end else begin
          state_nx = WAIT;
`ifdef MICROSEQ_TIMEOUT_EN
          cnt_nx = '0;
`endif
        end
      end
      WAIT: begin
        if (advance) begin
          uaddr_nx = next_addr;
          state_nx = RUN;
`ifdef MICROSEQ_TIMEOUT_EN
        end else if (cnt == CNT_W'(MOC_TIMEOUT - 1)) begin
          uaddr_nx = TRAP_ADDR;
          state_nx = RUN;
          terr_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
`endif
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      uaddr <= RESET_ADDR;
    end else begin
      state <= state_nx;
      uaddr <= uaddr_nx;
    end
  end

`ifdef MICROSEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      timeout_err <= terr_nx;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  assign seq_state = state;

endmodule
